// File: rtl/sym_fir_pkg.sv
// Shared helpers for the symmetric FIR: width/level arithmetic and the output
// round-and-saturate step. Purely combinational / elaboration-time content.
// No ports; imported by sym_fir_adder_tree and sym_fir_pipe.
package sym_fir_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Number of live nodes at tree level lvl when level 0 holds n nodes.
  function automatic int level_cnt(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Derived sizes for the default build (DATA_W = COEF_W = 18, NTAPS = 21).
  // Each module re-derives its own copies from its actual parameters.
  localparam int DEF_DATA_W = 18;
  localparam int DEF_COEF_W = 18;
  localparam int DEF_NTAPS  = 21;
  localparam int NCOEF      = (DEF_NTAPS + 1) / 2;
  localparam int L          = clog2(NCOEF);
  localparam int ACC_W      = DEF_DATA_W + DEF_COEF_W + 1 + L;

  // Round-half-up, arithmetic shift right, then clamp to a signed out_w range.
  // The accumulator is carried as 64 bits, so accumulators wider than 63 bits
  // are not supported by this helper.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    else           r = acc;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/sym_fir_adder_tree.sv
// Registered pairwise adder tree with a matching valid shift register.
// Latency clog2(N) clocks; one level per clock, odd nodes pass through registered.
// No backpressure: accepts a new vector every clock.
// Ports: clk, reset (sync, active-high), in_i[N] / vld_i in, sum_o / vld_o out.
module sym_fir_adder_tree
  import sym_fir_pkg::*;
#(
  parameter int N    = 11,
  parameter int IN_W = 37
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic signed [IN_W-1:0]            in_i [N],
  input  logic                              vld_i,
  output logic signed [IN_W+clog2(N)-1:0]   sum_o,
  output logic                              vld_o
);

  localparam int LV = clog2(N);
  localparam int OW = IN_W + LV;

  // Every node carries the full output width, so no level can overflow.
  logic signed [OW-1:0] ext   [N];
  logic signed [OW-1:0] lvl_q [LV][N];
  logic [LV-1:0]        v_q;

  always_comb begin
    for (int k = 0; k < N; k++) ext[k] = OW'(in_i[k]);
  end

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int PCNT = level_cnt(N, l);
    logic signed [OW-1:0] src [N];

    if (l == 0) begin : g_s0
      assign src = ext;
    end else begin : g_sn
      assign src = lvl_q[l-1];
    end

    for (genvar k = 0; k < N; k++) begin : g_el
      if (2*k + 1 < PCNT) begin : g_add
        always_ff @(posedge clk) begin
          if (reset) lvl_q[l][k] <= '0;
          else       lvl_q[l][k] <= src[2*k] + src[2*k+1];
        end
      end else if (2*k < PCNT) begin : g_pass
        // Unpaired node at the end of a level rides along to the next one.
        always_ff @(posedge clk) begin
          if (reset) lvl_q[l][k] <= '0;
          else       lvl_q[l][k] <= src[2*k];
        end
      end else begin : g_zero
        always_ff @(posedge clk) begin
          lvl_q[l][k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
    end else begin
      v_q[0] <= vld_i;
      for (int i = 1; i < LV; i++) v_q[i] <= v_q[i-1];
    end
  end

  assign sum_o = lvl_q[LV-1][0];
  assign vld_o = v_q[LV-1];

endmodule

// File: rtl/sym_fir_pipe.sv
// Odd-length symmetric FIR with pre-add, double-buffered reloadable coefficients.
// Latency clog2((NTAPS+1)/2)+3 clocks from accept to y_valid (7 for 21 taps).
// No backpressure: one sample per clock, bubbles propagate as y_valid=0.
// Ports: clk, reset (sync, active-high); x_in/x_valid sample input;
//        coef_we/coef_addr/coef_data shadow-bank write; coef_swap shadow->active;
//        y/y_valid rounded, saturated output (y holds between valid results).
module sym_fir_pipe
  import sym_fir_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int COEF_W = 18,
  parameter int OUT_W  = 18,
  parameter int NTAPS  = 21   // odd, >= 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_W-1:0]                 x_in,
  input  logic                              x_valid,
  input  logic                              coef_we,
  input  logic [clog2((NTAPS+1)/2)-1:0]     coef_addr,
  input  logic [COEF_W-1:0]                 coef_data,
  input  logic                              coef_swap,
  output logic [OUT_W-1:0]                  y,
  output logic                              y_valid
);

  localparam int NCF      = (NTAPS + 1) / 2;
  localparam int CTR      = (NTAPS - 1) / 2;
  localparam int TREE_L   = clog2(NCF);
  localparam int P_W      = DATA_W + 1;
  localparam int M_W      = DATA_W + COEF_W + 1;
  localparam int ACC_BITS = M_W + TREE_L;

  // Largest positive Q1.(COEF_W-1) value: the pass-through centre tap.
  localparam logic signed [COEF_W-1:0] UNITY = {1'b0, {(COEF_W-1){1'b1}}};

  logic signed [DATA_W-1:0]   x_q   [NTAPS];
  logic signed [P_W-1:0]      p_q   [NCF];
  logic signed [M_W-1:0]      m_q   [NCF];
  logic signed [COEF_W-1:0]   shd_q [NCF];
  logic signed [COEF_W-1:0]   act_q [NCF];
  logic                       x_vld_q;
  logic                       p_vld_q;
  logic                       m_vld_q;
  logic signed [ACC_BITS-1:0] sum;
  logic                       sum_vld;
  logic signed [OUT_W-1:0]    y_d;
  logic signed [OUT_W-1:0]    y_q;
  logic                       y_vld_q;

  // Delay line only advances on accepted samples; valid bit follows every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
      x_vld_q <= 1'b0;
    end else begin
      x_vld_q <= x_valid;
      if (x_valid) begin
        x_q[0] <= x_in;
        for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
      end
    end
  end

  // Coefficient banks. The swap reads shadow before this edge's write lands,
  // so a simultaneous write+swap moves the old shadow value into active.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCF; k++) begin
        shd_q[k] <= (k == NCF - 1) ? UNITY : '0;
        act_q[k] <= (k == NCF - 1) ? UNITY : '0;
      end
    end else begin
      if (coef_swap) begin
        for (int k = 0; k < NCF; k++) act_q[k] <= shd_q[k];
      end
      if (coef_we && (int'(coef_addr) < NCF)) shd_q[coef_addr] <= coef_data;
    end
  end

  // Pre-add symmetric pairs; centre tap has no partner.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCF; k++) p_q[k] <= '0;
      p_vld_q <= 1'b0;
    end else begin
      for (int k = 0; k < NCF - 1; k++) p_q[k] <= P_W'(x_q[k]) + P_W'(x_q[NTAPS-1-k]);
      p_q[NCF-1] <= P_W'(x_q[CTR]);
      p_vld_q    <= x_vld_q;
    end
  end

  // Products sample the active bank at this edge, so a swap only affects
  // samples that have not yet reached this stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NCF; k++) m_q[k] <= '0;
      m_vld_q <= 1'b0;
    end else begin
      for (int k = 0; k < NCF; k++) m_q[k] <= M_W'(p_q[k]) * M_W'(act_q[k]);
      m_vld_q <= p_vld_q;
    end
  end

  sym_fir_adder_tree #(
    .N    (NCF),
    .IN_W (M_W)
  ) u_tree (
    .clk   (clk),
    .reset (reset),
    .in_i  (m_q),
    .vld_i (m_vld_q),
    .sum_o (sum),
    .vld_o (sum_vld)
  );

  always_comb begin
    y_d = OUT_W'(round_sat(64'(sum), COEF_W - 1, OUT_W));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q     <= '0;
      y_vld_q <= 1'b0;
    end else begin
      y_vld_q <= sum_vld;
      if (sum_vld) y_q <= y_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_vld_q;

endmodule

// File: tb/tb_sym_fir_pipe.sv
module tb_sym_fir_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] x_in;
  logic        x_valid;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [17:0] coef_data;
  logic        coef_swap;
  logic [17:0] y;
  logic        y_valid;

  sym_fir_pipe #(
    .DATA_W (18),
    .COEF_W (18),
    .OUT_W  (18),
    .NTAPS  (21)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_swap (coef_swap),
    .y         (y),
    .y_valid   (y_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture on the falling edge, tagged with the rising edge that produced it.
  int yq[$];
  int tq[$];
  always @(negedge clk) begin
    if (y_valid) begin
      yq.push_back(int'($signed(y)));
      tq.push_back(cyc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qy(input int i);
    if (i < yq.size()) return yq[i];
    return -999999;
  endfunction

  function automatic int qt(input int i);
    if (i < tq.size()) return tq[i];
    return -999999;
  endfunction

  task automatic drive(input int x, input logic v);
    @(negedge clk);
    x_in      = 18'(x);
    x_valid   = v;
    coef_we   = 1'b0;
    coef_swap = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1'b0);
  endtask

  task automatic wr(input int a, input int d, input logic sw);
    @(negedge clk);
    x_valid   = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 4'(a);
    coef_data = 18'(d);
    coef_swap = sw;
  endtask

  task automatic swap();
    @(negedge clk);
    x_valid   = 1'b0;
    coef_we   = 1'b0;
    coef_swap = 1'b1;
  endtask

  task automatic clearq();
    yq.delete();
    tq.delete();
  endtask

  task automatic run_impulse();
    drive(65536, 1'b1);
    repeat (20) drive(0, 1'b1);
    idle(10);
  endtask

  // Hand-computed round(c * 65536 / 2^17), outer tap first.
  int ch[11] = '{1023, 1474, 831, -861, -2667, -3112, -1006, 3726, 9739, 14772, 16732};
  int cf[11] = '{2045, 2948, 1662, -1723, -5334, -6224, -2012, 7451, 19477, 29543, 33463};

  initial begin
    int first_acc;
    int exp_v;
    int acc_x[$];
    int acc_t[$];
    logic [31:0] pat;

    reset     = 1'b1;
    x_in      = '0;
    x_valid   = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    coef_swap = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_y", int'(y), 0);
    chk("reset_y_valid", int'(y_valid), 0);
    reset = 1'b0;

    // Default impulse bank: constant 1000 appears after 10 accepted samples.
    idle(2);
    clearq();
    drive(1000, 1'b1);
    first_acc = cyc + 1;
    repeat (19) drive(1000, 1'b1);
    idle(10);
    chk("dc_count", yq.size(), 20);
    chk("dc_latency", qt(0) - first_acc, 7);
    for (int i = 0; i < 20; i++) chk($sformatf("dc_y%0d", i), qy(i), (i < 10) ? 0 : 1000);

    // Bubbles: y_valid pattern is the x_valid pattern delayed 7, values unchanged.
    repeat (21) drive(0, 1'b1);
    idle(10);
    clearq();
    pat = 32'b1011_0011_1000_1101_1110_0101_0011_0111;
    for (int i = 0; i < 32; i++) begin
      if (pat[i]) begin
        drive(10 * (acc_x.size() + 1), 1'b1);
        acc_x.push_back(10 * (acc_x.size() + 1));
        acc_t.push_back(cyc + 1);
      end else begin
        drive(0, 1'b0);
      end
    end
    idle(10);
    chk("gap_count", yq.size(), acc_x.size());
    for (int j = 0; j < acc_x.size(); j++) begin
      exp_v = (j >= 10) ? acc_x[j-10] : 0;
      chk($sformatf("gap_t%0d", j), qt(j), acc_t[j] + 7);
      chk($sformatf("gap_y%0d", j), qy(j), exp_v);
    end

    // Real coefficient set, impulse response.
    repeat (21) drive(0, 1'b1);
    idle(10);
    for (int a = 0; a < 11; a++) wr(a, cf[a], 1'b0);
    swap();
    clearq();
    run_impulse();
    chk("imp_count", yq.size(), 21);
    for (int n = 0; n < 21; n++) chk($sformatf("imp_y%0d", n), qy(n), ch[(n <= 10) ? n : 20 - n]);

    // Same-cycle write and swap: active takes the pre-write shadow value.
    wr(10, 40000, 1'b0);
    wr(10, 20000, 1'b1);
    idle(1);
    clearq();
    run_impulse();
    chk("ws_centre", qy(10), 20000);
    chk("ws_outer0", qy(0), 1023);
    chk("ws_outer20", qy(20), 1023);

    // Out-of-range address write is dropped; the plain swap exposes the new centre.
    wr(11, 77777, 1'b0);
    swap();
    idle(1);
    clearq();
    run_impulse();
    chk("oor_count", yq.size(), 21);
    for (int n = 0; n < 21; n++) begin
      exp_v = (n == 10) ? 10000 : ch[(n <= 10) ? n : 20 - n];
      chk($sformatf("oor_y%0d", n), qy(n), exp_v);
    end

    // Saturation in both directions.
    for (int a = 0; a < 11; a++) wr(a, 131071, 1'b0);
    swap();
    clearq();
    repeat (25) drive(131071, 1'b1);
    idle(10);
    chk("sat_pos_count", yq.size(), 25);
    chk("sat_pos_y", qy(24), 131071);
    clearq();
    repeat (25) drive(-131072, 1'b1);
    idle(10);
    chk("sat_neg_y", qy(24), -131072);

    // Reset mid-stream: outputs clear, in-flight samples vanish, banks revert.
    repeat (10) drive(1000, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_y", int'(y), 0);
    chk("mid_reset_y_valid", int'(y_valid), 0);
    reset   = 1'b0;
    x_valid = 1'b0;
    clearq();
    idle(12);
    chk("no_stale_valid", yq.size(), 0);
    drive(1000, 1'b1);
    first_acc = cyc + 1;
    repeat (14) drive(1000, 1'b1);
    idle(10);
    chk("post_rst_count", yq.size(), 15);
    chk("post_rst_latency", qt(0) - first_acc, 7);
    chk("post_rst_y0", qy(0), 0);
    chk("post_rst_y9", qy(9), 0);
    chk("post_rst_y10", qy(10), 1000);
    chk("post_rst_y14", qy(14), 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
